// File: rtl/act_pkg.sv
// Shared types and constants for the SELU activation scheduler slice.
package act_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned LUT_DEPTH = 256;
   localparam int unsigned ADDR_W    = $clog2(LUT_DEPTH);
   localparam int unsigned TAG_IDX_W = 3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY,
      ST_DRAIN,
      ST_LOAD
   } state_e;

   typedef struct packed {
      logic                 valid;
      logic [TAG_IDX_W-1:0] idx;
      logic                 last;
   } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request picker: first set request searching upward from last_i+1.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDX_W-1:0]   last_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDX_W-1:0]   idx_o
);

   logic             found;
   logic [IDX_W-1:0] cand;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         cand = IDX_W'((32'(last_i) + i) % NUM_REQ);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/selu_act_sched.sv
// Packet-locked round-robin scheduler for the shared SELU LUT unit, with
// result tagging and drain-then-load sequencing of runtime table reloads.
module selu_act_sched
   import act_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned LAT     = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [DATA_W*NUM_REQ-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      act_in_valid,
   output logic [DATA_W-1:0]         act_in_data,
   input  logic [DATA_W-1:0]         act_out_data,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_data,
   output logic                      rsp_last,
   input  logic                      cfg_start,
   input  logic                      cfg_we,
   input  logic [ADDR_W-1:0]         cfg_addr,
   input  logic [DATA_W-1:0]         cfg_wdata,
   input  logic                      cfg_done,
   output logic                      cfg_busy,
   output logic                      lut_we,
   output logic [ADDR_W-1:0]         lut_addr,
   output logic [DATA_W-1:0]         lut_wdata
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CNT_W = $clog2(LAT + 1);

   state_e               state_q;
   logic [IDX_W-1:0]     grant_q;
   logic [NUM_REQ-1:0]   gnt_oh_q;
   logic [IDX_W-1:0]     last_grant_q;
   logic                 pend_q;
   logic [CNT_W-1:0]     cnt_q;
   tag_t                 tag_q [LAT];
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic [DATA_W-1:0]    rsp_data_q;
   logic                 rsp_last_q;
   logic                 lut_we_q;
   logic [ADDR_W-1:0]    lut_addr_q;
   logic [DATA_W-1:0]    lut_wdata_q;

   logic [NUM_REQ-1:0]   arb_gnt;
   logic [IDX_W-1:0]     arb_idx;
   logic                 hs_last;
   logic                 reload_req;
   logic [NUM_REQ-1:0]   rsp_valid_d;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i  (req_valid),
      .last_i (last_grant_q),
      .gnt_o  (arb_gnt),
      .idx_o  (arb_idx)
   );

   assign req_ready    = (state_q == ST_BUSY) ? gnt_oh_q : '0;
   assign act_in_valid = |(req_valid & req_ready);
   assign act_in_data  = act_in_valid ? req_data[32'(grant_q)*DATA_W +: DATA_W] : '0;
   assign hs_last      = act_in_valid & req_last[grant_q];
   assign reload_req   = pend_q | cfg_start;

   // Pending reload is only honoured at packet boundaries; cfg_start never cuts a packet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         gnt_oh_q     <= '0;
         last_grant_q <= IDX_W'(NUM_REQ - 1);
         pend_q       <= 1'b0;
         cnt_q        <= '0;
      end else begin
         if (cfg_start) pend_q <= 1'b1;
         unique case (state_q)
            ST_IDLE: begin
               if (reload_req) begin
                  state_q <= ST_DRAIN;
                  cnt_q   <= CNT_W'(LAT);
               end else if (|arb_gnt) begin
                  state_q      <= ST_BUSY;
                  grant_q      <= arb_idx;
                  gnt_oh_q     <= arb_gnt;
                  last_grant_q <= arb_idx;
               end
            end
            ST_BUSY: begin
               if (hs_last) begin
                  if (reload_req) begin
                     state_q <= ST_DRAIN;
                     cnt_q   <= CNT_W'(LAT);
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end
            end
            ST_DRAIN: begin
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q <= CNT_W'(1)) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               if (cfg_done) begin
                  state_q <= ST_IDLE;
                  pend_q  <= 1'b0;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign cfg_busy = pend_q;

   always_comb begin
      rsp_valid_d = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         rsp_valid_d[i] = tag_q[LAT-1].valid && (tag_q[LAT-1].idx == TAG_IDX_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < LAT; i++) tag_q[i] <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         rsp_last_q  <= 1'b0;
      end else begin
         tag_q[0] <= '{valid: act_in_valid, idx: TAG_IDX_W'(grant_q), last: hs_last};
         for (int unsigned i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
         rsp_valid_q <= rsp_valid_d;
         rsp_last_q  <= tag_q[LAT-1].valid & tag_q[LAT-1].last;
         if (tag_q[LAT-1].valid) rsp_data_q <= act_out_data;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_last  = rsp_last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lut_we_q    <= 1'b0;
         lut_addr_q  <= '0;
         lut_wdata_q <= '0;
      end else begin
         lut_we_q <= (state_q == ST_LOAD) && cfg_we;
         if ((state_q == ST_LOAD) && cfg_we) begin
            lut_addr_q  <= cfg_addr;
            lut_wdata_q <= cfg_wdata;
         end
      end
   end

   assign lut_we    = lut_we_q;
   assign lut_addr  = lut_addr_q;
   assign lut_wdata = lut_wdata_q;

endmodule

// File: doc/selu_act_sched.md
# selu_act_sched

Scheduler and configuration controller for the shared int8 SELU LUT activation unit. It arbitrates packets of int8 samples from NUM_REQ requesters onto the single unit (round-robin, packet-locked) and tags each issued sample so its result returns to the right requester. It also sequences runtime LUT reloads: it stops new packets, drains in-flight lookups, then forwards table writes. It sits between the conv/accumulator output lanes and the LUT activation unit (write-port variant).

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- LAT, 2, clock edges from issue into the activation unit until its out_data holds the result
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- req_valid  in  NUM_REQ  per-requester sample valid
- req_data  in  8*NUM_REQ  signed int8 sample; lane i at [8i+7:8i]
- req_last  in  NUM_REQ  last sample of the packet
- req_ready  out  NUM_REQ  per-requester accept
- act_in_valid  out  1  to activation unit in_valid
- act_in_data  out  8  to activation unit in_data
- act_out_data  in  8  from activation unit out_data (its out_valid is not used)
- rsp_valid  out  NUM_REQ  one-hot result strobe; no backpressure
- rsp_data  out  8  signed int8 SELU result
- rsp_last  out  1  result closes a packet
- cfg_start  in  1  request LUT reload (pulse)
- cfg_we, cfg_addr[7:0], cfg_wdata[7:0]  in  write beat (index = raw two's-complement bits of x)
- cfg_done  in  1  reload finished (pulse)
- cfg_busy  out  1  reload pending or in progress
- lut_we, lut_addr[7:0], lut_wdata[7:0]  out  to activation unit write port

## Operation
- FSM states: IDLE, BUSY, DRAIN, LOAD. Reset state is IDLE.
- IDLE, no reload pending, and any req_valid high:
  - Grant the first requester with req_valid set, searching round-robin from last_grant+1 mod NUM_REQ.
  - Go to BUSY. This costs one arbitration bubble cycle.
  - last_grant resets to NUM_REQ-1, so requester 0 wins first.
- BUSY:
  - req_ready is high only for the granted lane.
  - act_in_valid = req_valid[g] & req_ready[g], and act_in_data = req_data lane g. Both are combinational.
  - A handshake with req_last set ends the packet. The FSM then goes to DRAIN if a reload is pending, otherwise to IDLE.
- cfg_start in any state sets the pending flag and cfg_busy. It never truncates a packet.
  - From IDLE, the FSM goes to DRAIN next cycle.
  - A cfg_start while cfg_busy is already high is ignored.
- DRAIN:
  - A counter loads LAT and decrements to 0. When it reaches 0, the FSM goes to LOAD.
  - This guarantees that every issued lookup has returned before the table changes.
- LOAD:
  - lut_we/addr/wdata are the registered copies of cfg_we/addr/wdata (one cycle delay).
  - cfg_we outside LOAD is dropped.
  - cfg_done moves the FSM to IDLE and clears pending and cfg_busy at the same edge.
  - A cfg_we in the same cycle as cfg_done is still forwarded.
- Tag pipeline:
  - Per issue, push {valid, grant index, last} into a LAT-deep shift register.
  - At the output stage, register rsp_valid = onehot(tag), rsp_data = act_out_data and rsp_last = tag.last.
  - Idle stages carry valid=0.
- Reset mid-operation clears the FSM, tags, pending flag and counters. In-flight results are discarded.

## Timing
- Reset values: req_ready=0, act_in_valid=0, act_in_data=0, rsp_valid=0, rsp_data=0, rsp_last=0, cfg_busy=0, lut_we=0, lut_addr=0, lut_wdata=0.
- Latency: a handshake at edge k gives rsp_valid high in the cycle following edge k+LAT. With LAT=2 this is 3 cycles of output after the handshake.
- Throughput: 1 sample/cycle within a packet, with 1 bubble per packet switch.
- cfg_start → first forwardable write: LAT+1 cycles from IDLE. From BUSY, add the rest of the packet.
- cfg_start in the same cycle as an IDLE grant: the reload wins and no grant is made.

## Structure
- Shared package act_pkg holds: DATA_W=8, LUT_DEPTH=256, the state enum, and the tag struct {valid, idx, last}.
- Sub-module rr_arbiter (NUM_REQ, req vector + last_grant → one-hot grant + index).
- The activation unit is instantiated by the parent, not inside this block.

## Test plan
- Single packet: req 0 sends 10 samples x=-3..6 back-to-back with last on x=6. Required: 10 consecutive rsp_valid[0] strobes, LAT cycles after each handshake, with rsp_last only on the 10th and data equal to the LUT golden values.
- Contention: all 4 requesters hold valid with 3-sample packets. Required: grant order 0,1,2,3,0, one bubble between packets, and no interleaving within a packet.
- Reload mid-packet: cfg_start at the 2nd of a 5-sample packet. Required: the packet completes, DRAIN lasts LAT cycles, and there is no act_in_valid from the last issue until after cfg_done.
- Reload content: write entry 0x80 (x=-128) = 0x11 and issue x=-128 after cfg_done. Required: rsp_data=0x11, and lut_we follows cfg_we by 1 cycle.
- Boundary values: x=127, 0, -1 and -128 through requester 3. Required: results route only to rsp_valid[3], and out-of-LOAD cfg_we produces no lut_we.
- Async reset with 2 results in flight. Required: all outputs go to reset values immediately, and no rsp_valid appears after rst_n deasserts.
